// File: rtl/addsub_iter_pkg.sv
// Shared ALU definitions: operation codes and the add/sub FSM state encoding.
// Imported by the iterative add/sub unit and its interface users.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_iter_if.sv
// Valid/ready bus of the iterative add/sub unit.
// master: producer/consumer side; slave: the unit (in_* handshake, out_* result + flags).
interface addsub_iter_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zf;
    logic             sf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zf, sf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, cout, ovf, zf, sf
    );
endinterface

// File: rtl/addsub_iter_chunk.sv
// Combinational CHUNK-bit ripple adder slice.
// Ports: x, y operands, cin carry in; s sum, cout carry out.
module addsub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout = c[CHUNK];
    end
endmodule

// File: rtl/addsub_iter.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit slice per clock, with ZF/SF/OF/carry.
// Ports: clk, reset (sync, active-high), bus (slave side of addsub_iter_if).
module addsub_iter #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         reset,
    addsub_iter_if.slave bus
);
    import alu_pkg::*;

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("addsub_iter: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zf_q;
    logic             sf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] xs;
    logic [CHUNK-1:0] ys;
    logic [CHUNK-1:0] ss;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x    (xs),
        .y    (ys),
        .cin  (carry_q),
        .s    (ss),
        .cout (carry_d)
    );

    // Single shared slice adder: route the current slice in, merge its sum back.
    always_comb begin
        xs    = a_q[idx_q*CHUNK +: CHUNK];
        ys    = b_q[idx_q*CHUNK +: CHUNK];
        res_d = res_q;
        res_d[idx_q*CHUNK +: CHUNK] = ss;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zf_q        <= 1'b1;
            sf_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        // Invert once here; carry-in of 1 completes A + ~B + 1.
                        b_q        <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        carry_q    <= bus.op;
                        idx_q      <= '0;
                        res_q      <= '0;
                        zf_q       <= 1'b1;
                        sf_q       <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        idx_q       <= '0;
                        cout_q      <= carry_d;
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (res_d[WIDTH-1] != a_q[WIDTH-1]);
                        zf_q        <= (res_d == '0);
                        sf_q        <= res_d[WIDTH-1];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zf        = zf_q;
    assign bus.sf        = sf_q;
endmodule

// File: tb/tb_addsub_iter.sv
// Directed bench for addsub_iter: a 64/16 instance and a degenerate 8/8 instance.
module tb_addsub_iter;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   lat;

    addsub_iter_if #(.WIDTH(64)) b64 ();
    addsub_iter_if #(.WIDTH(8))  b8 ();

    addsub_iter #(.WIDTH(64), .CHUNK(16)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (b64.slave)
    );

    addsub_iter #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run64(input logic op, input logic [63:0] a, input logic [63:0] b,
                         output int l);
        b64.in_valid = 1'b1;
        b64.op       = op;
        b64.a        = a;
        b64.b        = b;
        step();
        b64.in_valid = 1'b0;
        l = 0;
        while (b64.out_valid !== 1'b1 && l < 20) begin
            step();
            l++;
        end
    endtask

    task automatic run8(input logic op, input logic [7:0] a, input logic [7:0] b,
                        output int l);
        b8.in_valid = 1'b1;
        b8.op       = op;
        b8.a        = a;
        b8.b        = b;
        step();
        b8.in_valid = 1'b0;
        l = 0;
        while (b8.out_valid !== 1'b1 && l < 20) begin
            step();
            l++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        b64.in_valid = 1'b0; b64.op = OP_ADD; b64.a = '0; b64.b = '0; b64.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.op  = OP_ADD; b8.a  = '0; b8.b  = '0; b8.out_ready  = 1'b1;
        step();
        step();
        chk("rst_in_ready", 64'(b64.in_ready), 64'd1);
        chk("rst_out_valid", 64'(b64.out_valid), 64'd0);
        chk("rst_result", b64.result, 64'd0);
        chk("rst_zf", 64'(b64.zf), 64'd1);
        chk("rst_flags", {61'd0, b64.cout, b64.ovf, b64.sf}, 64'd0);
        reset = 1'b0;
        step();

        // 7FFF..F + 1: signed overflow into the sign bit.
        run64(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat);
        chk("ovf_lat", 64'(lat), 64'd4);
        chk("ovf_res", b64.result, 64'h8000_0000_0000_0000);
        chk("ovf_flags", {60'd0, b64.cout, b64.ovf, b64.zf, b64.sf}, 64'b0101);
        chk("ovf_in_ready", 64'(b64.in_ready), 64'd0);
        step();
        chk("ovf_idle_rdy", 64'(b64.in_ready), 64'd1);
        chk("ovf_idle_vld", 64'(b64.out_valid), 64'd0);

        // Carry crossing from slice 0 into slice 1.
        run64(OP_ADD, 64'h0000_0000_0000_FFFF, 64'd1, lat);
        chk("xc_res", b64.result, 64'h0000_0000_0001_0000);
        chk("xc_flags", {60'd0, b64.cout, b64.ovf, b64.zf, b64.sf}, 64'b0000);
        step();

        run64(OP_SUB, 64'd5, 64'd5, lat);
        chk("sub0_res", b64.result, 64'd0);
        chk("sub0_flags", {60'd0, b64.cout, b64.ovf, b64.zf, b64.sf}, 64'b1010);
        step();

        run64(OP_SUB, 64'd0, 64'd1, lat);
        chk("borrow_res", b64.result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("borrow_flags", {60'd0, b64.cout, b64.ovf, b64.zf, b64.sf}, 64'b0001);
        step();

        // Backpressure: result must hold and in_valid pulses must be ignored.
        b64.out_ready = 1'b0;
        run64(OP_ADD, 64'd3, 64'd4, lat);
        chk("bp_lat", 64'(lat), 64'd4);
        for (int i = 0; i < 3; i++) begin
            b64.in_valid = 1'b1;
            b64.a = 64'd100;
            b64.b = 64'd200;
            step();
            chk("bp_vld", 64'(b64.out_valid), 64'd1);
            chk("bp_rdy", 64'(b64.in_ready), 64'd0);
            chk("bp_res", b64.result, 64'd7);
        end
        b64.in_valid  = 1'b0;
        b64.out_ready = 1'b1;
        step();
        chk("bp_rel_vld", 64'(b64.out_valid), 64'd0);
        chk("bp_rel_rdy", 64'(b64.in_ready), 64'd1);

        // Reset wins over a simultaneous in_valid.
        reset = 1'b1;
        b64.in_valid = 1'b1;
        b64.op = OP_ADD;
        b64.a = 64'd1;
        b64.b = 64'd1;
        step();
        reset = 1'b0;
        b64.in_valid = 1'b0;
        step();
        chk("rstv_rdy", 64'(b64.in_ready), 64'd1);
        chk("rstv_vld", 64'(b64.out_valid), 64'd0);

        // Reset during the second RUN cycle discards the operation.
        b64.in_valid = 1'b1;
        b64.op = OP_SUB;
        b64.a = 64'd9;
        b64.b = 64'd2;
        step();
        b64.in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_rdy", 64'(b64.in_ready), 64'd1);
        chk("mrst_vld", 64'(b64.out_valid), 64'd0);
        chk("mrst_zf", 64'(b64.zf), 64'd1);
        chk("mrst_res", b64.result, 64'd0);

        run64(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, lat);
        chk("msub_lat", 64'(lat), 64'd4);
        chk("msub_res", b64.result, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("msub_flags", {60'd0, b64.cout, b64.ovf, b64.zf, b64.sf}, 64'b1100);
        step();

        // Degenerate 8/8 instance: single RUN cycle.
        run8(OP_ADD, 8'hFF, 8'h01, lat);
        chk("w8_lat", 64'(lat), 64'd1);
        chk("w8_res", 64'(b8.result), 64'h00);
        chk("w8_flags", {60'd0, b8.cout, b8.ovf, b8.zf, b8.sf}, 64'b1010);
        step();

        run8(OP_SUB, 8'h80, 8'h01, lat);
        chk("w8s_res", 64'(b8.result), 64'h7F);
        chk("w8s_flags", {60'd0, b8.cout, b8.ovf, b8.zf, b8.sf}, 64'b1100);
        step();
        chk("w8_idle", 64'(b8.in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/addsub_iter.md
# addsub_iter

Parametrised, multi-cycle integer add/subtract unit for the ALU datapath. It generalises the fixed 64-bit ripple add and subtract blocks to any `WIDTH`. The carry chain is split into `CHUNK`-bit slices, one slice evaluated per clock, which trades latency for a short critical path. It takes operands and an operation through a valid/ready handshake and returns the result with Y86-style condition flags (ZF, SF, OF) plus carry-out.

## Interface
Parameters:
- `WIDTH`, 64: operand/result width in bits.
- `CHUNK`, 16: bits processed per cycle. `WIDTH % CHUNK` must be 0, otherwise elaboration fails.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and op presented.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `op`  in  1  0 = add (A+B), 1 = subtract (A−B).
- `a`, `b`  in  `WIDTH`  operands, unsigned/two's-complement agnostic.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  `WIDTH`  sum or difference, modulo 2^WIDTH.
- `cout`  out  1  carry out of the MSB. For subtract, 1 means no borrow (a ≥ b unsigned).
- `ovf`  out  1  signed overflow (the codebase "error" flag).
- `zf`  out  1  `result == 0`.
- `sf`  out  1  `result[WIDTH-1]`.

## Operation
- Define N = WIDTH/CHUNK. The FSM has three states: IDLE, RUN and DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `a` and `b_eff` = `op ? ~b : b`, and latch `op`.
  - Carry register ← `op`, so subtract is A + ~B + 1.
  - Clear chunk index and result register, then go to RUN.
- **RUN:**
  - Each cycle, add slice `idx` of `a` and `b_eff` with the carry register.
  - Write the slice sum into `result[idx*CHUNK +: CHUNK]` and update the carry register.
  - Increment `idx`. After the slice with `idx == N-1` is written, go to DONE.
  - `in_valid` is ignored in this state.
- **DONE:**
  - `out_valid`=1.
  - `cout` = final carry.
  - `ovf` = (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]).
  - `zf` and `sf` are derived from the registered result.
  - On `out_valid && out_ready`, go to IDLE.
- Outputs `result`, `cout`, `ovf`, `zf` and `sf` are registered and held stable through DONE. Their values outside DONE are don't-care, but they are deterministic (last written).
- Arithmetic is purely modulo 2^WIDTH. There is no saturation.

## Timing
- **Reset values:**
  - State = IDLE, `in_ready`=1 (after reset deasserts), `out_valid`=0.
  - `result`=0, `cout`=0, `ovf`=0, `sf`=0.
  - `zf`=1, consistent with result=0.
  - `idx`=0.
- **Latency:**
  - Input accepted at edge t; slices are computed at edges t+1…t+N.
  - `out_valid` is high in the cycle after edge t+N.
  - Minimum issue interval is N+2 cycles: accept, N RUN cycles, one DONE cycle with `out_ready`=1.
- **Backpressure:** while `out_ready`=0 in DONE, all outputs hold and `in_ready` stays 0.
- **Reset mid-operation:** reset asserted in RUN or DONE returns to IDLE at that edge and discards the operation. `out_valid` drops the next cycle.
- **Reset with `in_valid`:** reset wins and the operand is not accepted.
- **CHUNK == WIDTH:** N=1, so one RUN cycle and 1-cycle latency.
- No overlap: a new operation cannot be accepted in the same edge that the result handshake completes. `in_ready` rises the cycle after.

## Structure
- Shared package `alu_pkg` holds:
  - `OP_ADD` = 1'b0 and `OP_SUB` = 1'b1.
  - The state encoding constants IDLE/RUN/DONE.
- Sub-module `addsub_chunk` #(`CHUNK`) is a combinational `CHUNK`-bit ripple adder.
  - Ports: `s`, `cout`, `x`, `y`, `cin`.
  - `addsub_iter` instantiates it exactly once and muxes slices into it via `idx`.
- `~b` is applied once at accept time, not per slice.

## Test plan
- **Add with overflow** (WIDTH=64, CHUNK=16): add 0x7FFF_FFFF_FFFF_FFFF + 1 → `result`=0x8000_0000_0000_0000, `ovf`=1, `sf`=1, `zf`=0, `cout`=0; `out_valid` exactly 4 cycles after the accept edge.
- **Cross-chunk carry:** add 0x0000_0000_0000_FFFF + 1 → 0x0000_0000_0001_0000, `cout`=0, `ovf`=0.
- **Subtract to zero and borrow:**
  - sub 5 − 5 → `result`=0, `zf`=1, `cout`=1, `ovf`=0.
  - sub 0 − 1 → 0xFFFF_FFFF_FFFF_FFFF, `sf`=1, `cout`=0, `ovf`=0.
- **Backpressure:** hold `out_ready`=0 for 3 cycles in DONE → outputs stable, `in_ready`=0, `in_valid` pulses ignored. On `out_ready`=1, IDLE next cycle.
- **Reset mid-RUN:** assert `reset` at the 2nd RUN cycle → next cycle IDLE, `in_ready`=1, `out_valid`=0, `zf`=1. A following sub 0x8000_0000_0000_0000 − 1 → 0x7FFF_FFFF_FFFF_FFFF, `ovf`=1.
- **Degenerate width** (WIDTH=8, CHUNK=8): add 0xFF + 0x01 → 0x00, `cout`=1, `zf`=1, latency 1 cycle.
